// File: rtl/mm_stream_ctrl.sv
// Fills A/B RAMs from s_*, runs the core via Start/Done, then streams RES on m_* (1 word per 2 cycles, held while m_tready=0).
// RAM writes land 1 cycle after each accepted beat; input is stalled outside IDLE/LOAD_*. MM_TLAST_CHECK_EN enables tlast_err.
module mm_stream_ctrl #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 9,
  parameter int RES_depth_bits = 9,
  parameter int M              = 64,
  parameter int N              = 8,
  parameter int P              = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [width-1:0]          s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  output logic [width-1:0]          m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      Start,
  input  logic                      Done,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      tlast_err
);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    LOAD_A   = 7'b0000010,
    LOAD_B   = 7'b0000100,
    COMPUTE  = 7'b0001000,
    OUT_READ = 7'b0010000,
    OUT_LOAD = 7'b0100000,
    OUT_SEND = 7'b1000000
  } state_t;

  localparam logic [A_depth_bits-1:0]   A_LAST   = A_depth_bits'(M * N - 1);
  localparam logic [B_depth_bits-1:0]   B_LAST   = B_depth_bits'(N * P - 1);
  localparam logic [RES_depth_bits-1:0] RES_LAST = RES_depth_bits'(M * P - 1);
  localparam logic [A_depth_bits-1:0]   A_ONE    = A_depth_bits'(1);
  localparam logic [B_depth_bits-1:0]   B_ONE    = B_depth_bits'(1);
  localparam logic [RES_depth_bits-1:0] RES_ONE  = RES_depth_bits'(1);

  state_t r_state, w_next;

  logic [A_depth_bits-1:0]   r_a_idx, r_a_addr;
  logic [B_depth_bits-1:0]   r_b_idx, r_b_addr;
  logic [RES_depth_bits-1:0] r_res_idx;
  logic [width-1:0]          r_a_dat, r_b_dat, r_m_dat;
  logic                      r_a_we, r_b_we, r_start, r_m_vld, r_m_last;

  logic                      w_load_a, w_load_b, w_s_hs, w_m_hs, w_a_last, w_b_last;
  logic                      w_rd_en;
  logic [RES_depth_bits-1:0] w_rd_addr;

  assign w_load_a = (r_state == IDLE) || (r_state == LOAD_A);
  assign w_load_b = (r_state == LOAD_B);
  assign s_tready = (w_load_a || w_load_b) && !reset;
  assign w_s_hs   = s_tvalid && s_tready;
  assign w_m_hs   = (r_state == OUT_SEND) && r_m_vld && m_tready;
  assign w_a_last = (r_a_idx == A_LAST);
  assign w_b_last = (r_b_idx == B_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Reads are issued combinationally so RES data is ready for capture in OUT_LOAD.
  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    case (r_state)
      IDLE, LOAD_A: if (s_tvalid) w_next = w_a_last ? LOAD_B : LOAD_A;
      LOAD_B:       if (s_tvalid && w_b_last) w_next = COMPUTE;
      COMPUTE:      if (Done) w_next = OUT_READ;
      OUT_READ: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_res_idx;
        w_next    = OUT_LOAD;
      end
      OUT_LOAD:     w_next = OUT_SEND;
      OUT_SEND: begin
        if (w_m_hs) begin
          if (r_m_last) begin
            w_next = IDLE;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_res_idx + RES_ONE;
            w_next    = OUT_LOAD;
          end
        end
      end
      default:      w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_idx   <= '0;
      r_a_addr  <= '0;
      r_a_dat   <= '0;
      r_a_we    <= 1'b0;
      r_b_idx   <= '0;
      r_b_addr  <= '0;
      r_b_dat   <= '0;
      r_b_we    <= 1'b0;
      r_start   <= 1'b0;
      r_res_idx <= '0;
      r_m_dat   <= '0;
      r_m_vld   <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_a_we <= 1'b0;
      r_b_we <= 1'b0;
      if (w_s_hs && w_load_a) begin
        r_a_we   <= 1'b1;
        r_a_addr <= r_a_idx;
        r_a_dat  <= s_tdata;
        r_a_idx  <= w_a_last ? '0 : r_a_idx + A_ONE;
      end
      if (w_s_hs && w_load_b) begin
        r_b_we   <= 1'b1;
        r_b_addr <= r_b_idx;
        r_b_dat  <= s_tdata;
        if (w_b_last) begin
          r_b_idx <= '0;
          r_start <= 1'b1;
        end else begin
          r_b_idx <= r_b_idx + B_ONE;
        end
      end
      if ((r_state == COMPUTE) && Done) begin
        r_start   <= 1'b0;
        r_res_idx <= '0;
      end
      if (r_state == OUT_LOAD) begin
        r_m_dat  <= RES_read_data_out;
        r_m_vld  <= 1'b1;
        r_m_last <= (r_res_idx == RES_LAST);
      end
      // Drop valid after each accepted word so it is never presented twice.
      if (w_m_hs) begin
        r_m_vld  <= 1'b0;
        r_m_last <= 1'b0;
        if (!r_m_last) r_res_idx <= r_res_idx + RES_ONE;
      end
    end
  end

`ifdef MM_TLAST_CHECK_EN
  logic r_tlast_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_tlast_err <= 1'b0;
    else if (w_s_hs && (s_tlast != (w_load_b && w_b_last)))
      r_tlast_err <= 1'b1;
  end
  assign tlast_err = r_tlast_err;
`else
  logic w_unused_tlast;
  assign w_unused_tlast = s_tlast;
  assign tlast_err      = 1'b0;
`endif

  assign A_write_en       = r_a_we;
  assign A_write_address  = r_a_addr;
  assign A_write_data_in  = r_a_dat;
  assign B_write_en       = r_b_we;
  assign B_write_address  = r_b_addr;
  assign B_write_data_in  = r_b_dat;
  assign Start            = r_start;
  assign RES_read_en      = w_rd_en;
  assign RES_read_address = w_rd_addr;
  assign m_tdata          = r_m_dat;
  assign m_tvalid         = r_m_vld;
  assign m_tlast          = r_m_last;

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Bench for mm_stream_ctrl: RAM and core models, write/output scoreboards, backpressure, sparse input and reset cases.
module tb_mm_stream_ctrl;
  localparam int W = 8, ADB = 9, BDB = 9, RDB = 9, M = 64, N = 8, P = 4;
  localparam int DONE_LAT = 100;
  localparam logic EXP_TLAST_ERR =
`ifdef MM_TLAST_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   s_tdata;
  logic           s_tvalid, s_tready, s_tlast;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid, m_tready, m_tlast;
  logic           Start;
  logic           Done = 1'b0;
  logic           A_write_en, B_write_en, RES_read_en, tlast_err;
  logic [ADB-1:0] A_write_address;
  logic [BDB-1:0] B_write_address;
  logic [RDB-1:0] RES_read_address;
  logic [W-1:0]   A_write_data_in, B_write_data_in;
  logic [W-1:0]   RES_read_data_out = '0;

  mm_stream_ctrl #(.width(W), .A_depth_bits(ADB), .B_depth_bits(BDB), .RES_depth_bits(RDB),
                   .M(M), .N(N), .P(P)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .Start(Start), .Done(Done),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address),
    .RES_read_data_out(RES_read_data_out), .tlast_err(tlast_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // RAM and core models
  logic [W-1:0] A_mem[M*N];
  logic [W-1:0] B_mem[N*P];
  logic [W-1:0] RES_mem[M*P];
  int core_cnt = 0;

  function automatic logic [W-1:0] core_dot(input int i, input int j);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s += A_mem[i*N+k] * B_mem[k*P+j];
    return s;
  endfunction

  always @(posedge clk) begin
    if (A_write_en) A_mem[A_write_address] <= A_write_data_in;
    if (B_write_en) B_mem[B_write_address] <= B_write_data_in;
    if (RES_read_en) RES_read_data_out <= RES_mem[RES_read_address];
  end

  always @(posedge clk) begin
    if (!Start) begin
      core_cnt <= 0;
      Done     <= 1'b0;
    end else if (!Done) begin
      if (core_cnt == DONE_LAT - 1) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < P; j++) RES_mem[i*P+j] <= core_dot(i, j);
        Done <= 1'b1;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // Scoreboards
  logic [ADB+W-1:0] qa[$];
  logic [BDB+W-1:0] qb[$];
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     a_stim[M*N];
  logic [W-1:0]     b_stim[N*P];
  int               beats = 0, exp_rd = 0;
  bit               prev_stall = 1'b0, prev_last = 1'b0;
  logic [W-1:0]     prev_dat = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (A_write_en) begin
        if (qa.size() == 0) check("a_wr_extra", A_write_en, 0);
        else check("a_wr", {A_write_address, A_write_data_in}, qa.pop_front());
      end
      if (B_write_en) begin
        if (qb.size() == 0) check("b_wr_extra", B_write_en, 0);
        else check("b_wr", {B_write_address, B_write_data_in}, qb.pop_front());
      end
      if (RES_read_en) begin
        check("rd_addr", RES_read_address, exp_rd);
        exp_rd++;
      end
      if (prev_stall) begin
        check("stall_vld", m_tvalid, 1);
        check("stall_dat", m_tdata, prev_dat);
        check("stall_last", m_tlast, prev_last);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("beat_count", beats + 1, M * P);
        else check("m_tdata", m_tdata, exp_q.pop_front());
        check("m_tlast", m_tlast, beats == M * P - 1);
        beats++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      prev_last  = m_tlast;
    end
  end

  // Output ready pattern: 0 always ready, 1 toggle with one 20-cycle gap, 2 never ready
  int rdy_mode = 0, stall_left = 0;
  bit stretched = 1'b0;
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          if (stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
          end else if (beats == 100 && !stretched) begin
            stretched  = 1'b1;
            stall_left = 19;
            m_tready   = 1'b0;
          end else begin
            m_tready = ~m_tready;
          end
        end
        default: m_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [W-1:0] d, input logic last, input logic is_b,
                      input logic [8:0] addr, input bit sparse, input bit final_b);
    int n;
    bit hs;
    if (sparse) while ($urandom_range(9, 0) < 7) begin s_tvalid = 1'b0; @(negedge clk); end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      hs = s_tready;
      if (hs && final_b) check("start_pre", Start, 0);
      @(posedge clk);
      if (hs) begin
        if (is_b) qb.push_back({addr, d});
        else      qa.push_back({addr, d});
      end
      @(negedge clk);
      n++;
    end
    if (!hs) check("s_tready_wait", s_tready, 1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (final_b) begin
      check("start_rise", Start, 1);
      check("b_last_we", B_write_en, 1);
    end
  endtask

  task automatic load_job(input bit rnd, input bit sparse, input int bad_a, input bit push_exp);
    logic [W-1:0] s;
    for (int i = 0; i < M*N; i++) a_stim[i] = rnd ? W'($urandom) : W'(2);
    for (int i = 0; i < N*P; i++) b_stim[i] = rnd ? W'($urandom) : W'(3);
    for (int i = 0; i < M*N; i++) send(a_stim[i], i == bad_a, 1'b0, 9'(i), sparse, 1'b0);
    for (int i = 0; i < N*P; i++) send(b_stim[i], i == N*P-1, 1'b1, 9'(i), sparse, i == N*P-1);
    if (push_exp)
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) begin
          s = '0;
          for (int k = 0; k < N; k++) s += a_stim[i*N+k] * b_stim[k*P+j];
          exp_q.push_back(s);
        end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!Done && n < 300) begin @(negedge clk); n++; end
    check("done_seen", Done, 1);
    check("done_lat", n, DONE_LAT);
    check("start_hold", Start, 1);
    check("s_stall", s_tready, 0);
    @(negedge clk);
    check("start_drop", Start, 0);
    check("rd0_en", RES_read_en, 1);
    check("rd0_addr", RES_read_address, 0);
  endtask

  task automatic run_job(input bit rnd, input bit sparse, input int bad_a, input int mode,
                         input logic exp_err);
    int n;
    beats = 0; exp_rd = 0; stretched = 1'b0; stall_left = 0; rdy_mode = mode;
    load_job(rnd, sparse, bad_a, 1'b1);
    wait_done();
    n = 0;
    while (beats < M*P && n < 4000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("beats_total", beats, M * P);
    check("exp_q_left", exp_q.size(), 0);
    check("a_wr_left", qa.size(), 0);
    check("b_wr_left", qb.size(), 0);
    check("m_tvalid_end", m_tvalid, 0);
    check("s_tready_end", s_tready, 1);
    check("tlast_err", tlast_err, exp_err);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {Start, A_write_en, B_write_en, RES_read_en, m_tvalid, m_tlast,
                       tlast_err, s_tready}, 0);
    check("rst_addr", {A_write_address, B_write_address, RES_read_address}, 0);
    check("rst_dat", {A_write_data_in, B_write_data_in, m_tdata}, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    #2 reset = 1'b0;
    @(negedge clk);

    run_job(1'b0, 1'b0, -1, 1, 1'b0);   // constant data, toggling ready + long stall
    run_job(1'b1, 1'b1, -1, 0, 1'b0);   // random data, sparse input, back-to-back

    // Reset while the core is computing
    rdy_mode = 0;
    load_job(1'b0, 1'b0, -1, 1'b0);
    repeat (10) @(negedge clk);
    check("pre_rst_start", Start, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_done", Done, 0);
    run_job(1'b0, 1'b0, -1, 0, 1'b0);

    // Reset while a word is waiting in OUT_SEND
    beats = 0; exp_rd = 0; rdy_mode = 2;
    load_job(1'b1, 1'b0, -1, 1'b1);
    wait_done();
    n = 0;
    while (!m_tvalid && n < 20) begin @(negedge clk); n++; end
    check("osend_vld", m_tvalid, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_osend_vld", m_tvalid, 0);
    check("rst_osend_rd", RES_read_en, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    @(negedge clk);

    run_job(1'b1, 1'b0, -1, 1, 1'b0);
    run_job(1'b0, 1'b0, 10, 0, EXP_TLAST_ERR);  // stray s_tlast on A beat 10

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
